// File: rtl/fa4_seq_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM state
// encodings and operation codes.
package fa4_seq_adder_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa4_seq_adder_ctrl_fa4.sv
// fa4: 4-bit ripple-carry adder slice built from single-bit full adders.
module fa4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [4:0] c;

    // Ripple the carry through four full-adder cells
    always_comb begin
        c    = '0;
        Sum  = '0;
        c[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            Sum[i]  = A[i] ^ B[i] ^ c[i];
            c[i+1]  = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
        end
        Cout = c[4];
    end

endmodule

// File: rtl/fa4_seq_adder_ctrl.sv
// fa4_seq_adder_ctrl: wide add/subtract performed one nibble per clock,
// LSB first, through a single fa4 slice. Carry is chained between cycles
// in carry_reg; the result is published only when the last nibble lands.
module fa4_seq_adder_ctrl
    import fa4_seq_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum_out,
    output logic                 cout_out,
    output logic                 ovf_out
);

    localparam int W = 4 * NIBBLES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;      // already inverted for subtract
    logic [W-1:0]     sum_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       fa_sum;
    logic             fa_cout;
    logic [W-1:0]     sum_next;
    logic             accept;

    // Select the current nibble of each operand for the shared slice
    always_comb begin
        a_nib = 4'(a_reg >> {idx, 2'b00});
        b_nib = 4'(b_reg >> {idx, 2'b00});
    end

    fa4 u_fa4 (
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry_reg),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // Merge the freshly computed nibble into the partial result
    always_comb begin
        sum_next = sum_reg;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                sum_next[n*4 +: 4] = fa_sum;
            end
        end
    end

    assign accept = (state != S_RUN) && start;

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum_out   <= '0;
            cout_out  <= 1'b0;
            ovf_out   <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= fa_cout;
                    if (idx == LAST_IDX) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum_out  <= sum_next;
                        cout_out <= fa_cout;
                        ovf_out  <= (a_reg[W-1] == b_reg[W-1]) &&
                                    (sum_next[W-1] != a_reg[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    done <= 1'b0;
                    if (accept) begin
                        state     <= S_RUN;
                        busy      <= 1'b1;
                        a_reg     <= a_in;
                        b_reg     <= (op_sub == OP_SUB) ? ~b_in : b_in;
                        carry_reg <= (op_sub == OP_SUB) ? 1'b1 : cin;
                        sum_reg   <= '0;
                        idx       <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa4_seq_adder_ctrl.sv
// Directed bench for fa4_seq_adder_ctrl with NIBBLES=4 (16-bit operands).
module tb_fa4_seq_adder_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic         cin;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         ovf_out;

    int errors = 0;
    int checks = 0;

    fa4_seq_adder_ctrl #(.NIBBLES(4), .IDX_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .cin      (cin),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .ovf_out  (ovf_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation from the current (post-edge) time and wait for done
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub, input string tag);
        int n;
        a_in   = a;
        b_in   = b;
        cin    = ci;
        op_sub = sub;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, " done_after_start"}, 32'(done), 32'd0);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, n, 32'd4);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_result(input string tag, input logic [W-1:0] s,
                              input logic co, input logic ov);
        chk({tag, " sum"}, 32'(sum_out), 32'(s));
        chk({tag, " cout"}, 32'(cout_out), 32'(co));
        chk({tag, " ovf"}, 32'(ovf_out), 32'(ov));
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        cin    = 1'b0;
        a_in   = '0;
        b_in   = '0;
        #2;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk_result("reset", 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Table-driven vectors, each started from IDLE
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, $sformatf("vec%0d", i));
            chk_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].co, vecs[i].ovf);
            tick();
            chk($sformatf("vec%0d idle_done", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d idle_busy", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d hold_sum", i), 32'(sum_out), 32'(vecs[i].sum));
            tick();
        end

        // start re-asserted during RUN with different operands is ignored
        begin
            int n;
            a_in = 16'h1111; b_in = 16'h2222; cin = 1'b0; op_sub = 1'b0;
            start = 1'b1;
            tick();
            a_in = 16'hFFFF; b_in = 16'hFFFF; cin = 1'b1; op_sub = 1'b1;
            tick();
            tick();
            start = 1'b0;
            n = 2;
            while (!done && n < 20) begin
                tick();
                n++;
            end
            chk("ignore latency", n, 32'd4);
            chk_result("ignore", 16'h3333, 1'b0, 1'b0);
        end
        tick();
        tick();

        // Back-to-back: start held in the DONE cycle
        run_op(16'h00F0, 16'h0F00, 1'b0, 1'b0, "b2b_first");
        chk_result("b2b_first", 16'h0FF0, 1'b0, 1'b0);
        chk("b2b_in_done", 32'(done), 32'd1);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "b2b_second");
        chk_result("b2b_second", 16'h0002, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run
        a_in = 16'h1234; b_in = 16'h1111; cin = 1'b0; op_sub = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midrst busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk_result("midrst", 16'h0000, 1'b0, 1'b0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        chk("postrst busy", 32'(busy), 32'd0);
        run_op(16'h0010, 16'h0020, 1'b0, 1'b0, "postrst");
        chk_result("postrst", 16'h0030, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
